// File: rtl/alu_op_sequencer.sv
// Purpose: sequences one op at a time onto the shared 32-bit ALU; multiply is done as 32 shift-and-add ALU passes.
// Latency: and/or/add/sub 2 cycles, mul ITER+1 cycles, illegal opcode 1 cycle from accept to rsp_valid_o.
// Backpressure: req_ready_o only in IDLE; a response is held in RESP until rsp_ready_i, with no new request accepted.
module alu_op_sequencer #(
  parameter int ITER = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  op_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] result_o,
  output logic        rsp_err_o,
  output logic [31:0] alu_data1_o,
  output logic [31:0] alu_data2_o,
  output logic [2:0]  alu_ctrl_o,
  input  logic [31:0] alu_data_i
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b011;

  // Iteration counter terminal value: the last multiply pass.
  localparam logic [4:0] CNT_LAST = 5'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;

  // Latched request. op1_q doubles as the multiplicand and op2_q as the
  // multiplier during MUL: they shift in place, since the single-pass ops
  // never need the original values after EXEC.
  logic [2:0]  op_q;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic [31:0] acc_q;
  logic [4:0]  cnt_q;

  logic        accept;
  logic        op_is_single;

  assign accept       = (state_q == S_IDLE) && req_valid_i;
  assign op_is_single = (op_i == OP_AND) || (op_i == OP_OR) ||
                        (op_i == OP_ADD) || (op_i == OP_SUB);

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          if (op_i == OP_MUL) begin
            state_d = S_MUL;
          end else if (op_is_single) begin
            state_d = S_EXEC;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_EXEC: state_d = S_RESP;
      S_MUL: begin
        // No early exit on a zero multiplier: latency is fixed.
        if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: handshake outputs from state only; ALU held quiet outside EXEC/MUL.
  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    alu_ctrl_o  = 3'b000;
    alu_data1_o = '0;
    alu_data2_o = '0;
    case (state_q)
      S_IDLE: req_ready_o = 1'b1;
      S_EXEC: begin
        alu_ctrl_o  = op_q;
        alu_data1_o = op1_q;
        alu_data2_o = op2_q;
      end
      S_MUL: begin
        alu_ctrl_o  = OP_ADD;
        alu_data1_o = acc_q;
        alu_data2_o = op2_q[0] ? op1_q : '0;
      end
      S_RESP: rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath: request capture, shift-and-add iteration and response registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q      <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_o  <= '0;
      rsp_err_o <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q  <= op_i;
            op1_q <= src1_i;
            op2_q <= src2_i;
            acc_q <= '0;
            cnt_q <= '0;
            if (!op_is_single && (op_i != OP_MUL)) begin
              // Illegal opcode is answered without touching the ALU.
              result_o  <= '0;
              rsp_err_o <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          result_o  <= alu_data_i;
          rsp_err_o <= 1'b0;
        end
        S_MUL: begin
          acc_q <= alu_data_i;
          op1_q <= op1_q << 1;
          op2_q <= op2_q >> 1;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == CNT_LAST) begin
            result_o  <= alu_data_i;
            rsp_err_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
